count_direction_decoder: RTL and testbench

Receive-side companion to the up/down counter. Samples a WIDTH-bit count stream, such as a counter's d_out, and recovers the count direction (the counter's mode). Declares lock after a run of consistent steps and flags illegal jumps. Sits downstream of a counter as a direction and integrity monitor.

---
 rtl/count_direction_decoder.sv | 139 +++++++++++++
 tb/tb_count_direction_decoder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/count_direction_decoder.sv
// Recovers count direction from a sampled up/down count stream, declares lock after
// LOCK_CNT consistent steps and flags illegal jumps. Optional macro DIR_CHANGE_ERR_EN
// makes a direction change while locked raise err (strict mode).
module count_direction_decoder #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [WIDTH-1:0] d_in,
  output logic             dir,
  output logic             locked,
  output logic             hold,
  output logic             err,
  output logic [7:0]       step_cnt,
  output logic [1:0]       state_dbg,
  output logic [3:0]       run_dbg
);

  // Handshake: d_in is consumed on every rising clk edge where valid=1; there is no
  // backpressure. All outputs are registered and reflect the sample one cycle later.

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_RUN = 4'(LOCK_CNT);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] prev, prev_nxt;
  logic [3:0]       run, run_nxt;
  logic             dir_nxt, locked_nxt, hold_nxt, err_nxt;
  logic [7:0]       step_cnt_nxt;

  logic [WIDTH-1:0] delta;
  logic             is_up, is_dn, is_hold;
  logic [7:0]       step_cnt_inc;
  logic [3:0]       run_acq;

  assign delta        = d_in - prev;
  assign is_up        = (delta == WIDTH'(1));
  assign is_dn        = !is_up && (delta == {WIDTH{1'b1}});
  assign is_hold      = (delta == '0);
  assign step_cnt_inc = (step_cnt == 8'hFF) ? 8'hFF : step_cnt + 8'd1;
  // Run length after a legal step while acquiring: extend if consistent, else restart at 1.
  assign run_acq      = ((run == 4'd0) || (dir == is_up)) ? run + 4'd1 : 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= EMPTY;
      prev     <= '0;
      run      <= '0;
      dir      <= 1'b0;
      locked   <= 1'b0;
      hold     <= 1'b0;
      err      <= 1'b0;
      step_cnt <= '0;
    end else begin
      state    <= state_nxt;
      prev     <= prev_nxt;
      run      <= run_nxt;
      dir      <= dir_nxt;
      locked   <= locked_nxt;
      hold     <= hold_nxt;
      err      <= err_nxt;
      step_cnt <= step_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    prev_nxt     = prev;
    run_nxt      = run;
    dir_nxt      = dir;
    locked_nxt   = locked;
    hold_nxt     = hold;
    err_nxt      = 1'b0;
    step_cnt_nxt = step_cnt;
    if (valid) begin
      prev_nxt = d_in;
      hold_nxt = 1'b0;
      case (state)
        EMPTY: begin
          state_nxt = ACQ;
          run_nxt   = '0;
        end
        ACQ: begin
          if (is_up || is_dn) begin
            dir_nxt      = is_up;
            run_nxt      = run_acq;
            step_cnt_nxt = step_cnt_inc;
            if (run_acq >= LOCK_RUN) begin
              state_nxt  = LOCKED;
              locked_nxt = 1'b1;
            end
          end else if (is_hold) begin
            hold_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
            run_nxt = '0;
          end
        end
        LOCKED: begin
          if ((is_up || is_dn) && (is_up == dir)) begin
            step_cnt_nxt = step_cnt_inc;
            run_nxt      = (run < LOCK_RUN) ? run + 4'd1 : LOCK_RUN;
          end else if (is_up || is_dn) begin
            // Mode change by the upstream counter: re-acquire in the new direction.
            dir_nxt      = is_up;
            locked_nxt   = 1'b0;
            run_nxt      = 4'd1;
            state_nxt    = ACQ;
            step_cnt_nxt = step_cnt_inc;
`ifdef DIR_CHANGE_ERR_EN
            err_nxt      = 1'b1;
`else
            err_nxt      = 1'b0;
`endif
          end else if (is_hold) begin
            hold_nxt = 1'b1;
          end else begin
            err_nxt    = 1'b1;
            locked_nxt = 1'b0;
            run_nxt    = '0;
            state_nxt  = ACQ;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  assign state_dbg = state;
  assign run_dbg   = run;

endmodule

// File: tb/tb_count_direction_decoder.sv
// Directed-vector bench for count_direction_decoder (WIDTH=4, LOCK_CNT=3).
module tb_count_direction_decoder;

  localparam int W = 4;
  localparam logic [1:0] S_EMPTY  = 2'd0;
  localparam logic [1:0] S_ACQ    = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;
`ifdef DIR_CHANGE_ERR_EN
  localparam logic CHG_ERR = 1'b1;
`else
  localparam logic CHG_ERR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         valid = 1'b0;
  logic [W-1:0] d_in = '0;
  logic         dir, locked, hold, err;
  logic [7:0]   step_cnt;
  logic [1:0]   state_dbg;
  logic [3:0]   run_dbg;

  int errors = 0;
  int checks = 0;

  count_direction_decoder #(.WIDTH(W), .LOCK_CNT(3)) dut (
    .clk(clk), .rst(rst), .valid(valid), .d_in(d_in),
    .dir(dir), .locked(locked), .hold(hold), .err(err),
    .step_cnt(step_cnt), .state_dbg(state_dbg), .run_dbg(run_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    valid = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // drivers: one valid sample per call, outputs sampled #1 after the capturing edge
  task automatic send(input logic [W-1:0] d);
    @(negedge clk);
    valid = 1'b1;
    d_in  = d;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  int exp_step;
  logic [W-1:0] d;

  initial begin
    do_reset();

    // 1. asynchronous reset mid-stream
    send(4'd5); send(4'd6); send(4'd7); send(4'd8);
    check("pre_rst_lock", locked, 1'b1);
    @(negedge clk);
    valid = 1'b1;
    d_in  = 4'd9;
    #2 rst = 1'b0;
    #1;
    check("rst_dir", dir, 1'b0);
    check("rst_locked", locked, 1'b0);
    check("rst_hold", hold, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_step", step_cnt, 8'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      valid = ~valid;
      @(posedge clk);
      #1;
      check("rst_held_step", step_cnt, 8'd0);
      check("rst_held_state", state_dbg, S_EMPTY);
    end
    @(negedge clk);
    valid = 1'b0;
    rst   = 1'b1;
    send(4'd12);
    check("first_err", err, 1'b0);
    check("first_state", state_dbg, S_ACQ);
    check("first_step", step_cnt, 8'd0);
    send(4'd13);
    check("second_step", step_cnt, 8'd1);
    check("second_dir", dir, 1'b1);

    // 2. up lock 3,4,5,6
    do_reset();
    send(4'd3);
    check("up_locked0", locked, 1'b0);
    send(4'd4);
    check("up_dir1", dir, 1'b1);
    send(4'd5);
    check("up_locked2", locked, 1'b0);
    send(4'd6);
    check("up_locked", locked, 1'b1);
    check("up_dir", dir, 1'b1);
    check("up_step", step_cnt, 8'd3);

    // 3. wrap both ways
    do_reset();
    send(4'd14); send(4'd15);
    check("wrap_err_a", err, 1'b0);
    send(4'd0);
    check("wrap_err_b", err, 1'b0);
    send(4'd1);
    check("wrap_up_locked", locked, 1'b1);
    check("wrap_up_dir", dir, 1'b1);
    send(4'd1);
    check("wrap_hold", hold, 1'b1);
    send(4'd0);
    check("wrap_dn_dir", dir, 1'b0);
    check("wrap_dn_err", err, CHG_ERR);
    check("wrap_dn_locked0", locked, 1'b0);
    send(4'd15);
    check("wrap_dn_err2", err, 1'b0);
    send(4'd14);
    check("wrap_dn_locked", locked, 1'b1);
    check("wrap_dn_dir2", dir, 1'b0);
    check("wrap_step", step_cnt, 8'd6);

    // 4. jump
    do_reset();
    send(4'd5); send(4'd6); send(4'd7);
    send(4'd10);
    check("jump_err", err, 1'b1);
    check("jump_locked", locked, 1'b0);
    check("jump_step", step_cnt, 8'd2);
    check("jump_run", run_dbg, 4'd0);
    idle();
    check("jump_err_pulse", err, 1'b0);
    send(4'd11);
    check("after_jump_err", err, 1'b0);
    check("after_jump_run", run_dbg, 4'd1);
    check("after_jump_step", step_cnt, 8'd3);

    // jump while locked drops lock
    send(4'd12); send(4'd13);
    check("lk_before_jump", state_dbg, S_LOCKED);
    send(4'd2);
    check("lk_jump_err", err, 1'b1);
    check("lk_jump_state", state_dbg, S_ACQ);
    check("lk_jump_locked", locked, 1'b0);

    // 5. reversal and hold
    do_reset();
    send(4'd4); send(4'd5); send(4'd6); send(4'd7);
    send(4'd7);
    check("rev_hold", hold, 1'b1);
    check("rev_hold_locked", locked, 1'b1);
    send(4'd6);
    check("rev_dir", dir, 1'b0);
    check("rev_locked", locked, 1'b0);
    check("rev_hold_clr", hold, 1'b0);
    check("rev_err", err, CHG_ERR);
    check("rev_run", run_dbg, 4'd1);
    idle();
    check("rev_err_pulse", err, 1'b0);

    // 6. gaps and saturation
    do_reset();
    d = 4'd0;
    send(d);
    exp_step = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        check("gap_step", step_cnt, exp_step);
        check("gap_err", err, 1'b0);
        check("gap_dir", dir, (exp_step == 0) ? 1'b0 : 1'b1);
      end
      d = d + 4'd1;
      send(d);
      exp_step = (exp_step < 255) ? exp_step + 1 : 255;
      check("sat_step", step_cnt, exp_step);
      check("sat_err", err, 1'b0);
    end
    check("sat_final", step_cnt, 8'd255);
    check("sat_locked", locked, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
